hilo_mul_unit: RTL and testbench

//  Execute-stage HI/LO unit. Consumes ALUCtl/HiLoWrite from the ALU control decoder and runs the multiply family
//  (mult, multu, madd, msub) on an iterative shift-add datapath. Owns the HI/LO registers and handles mthi, mtlo,

---
 rtl/hilo_pkg.sv | 36 +++
 rtl/mul_iter_core.sv | 72 +++++++
 rtl/hilo_mul_unit.sv | 141 ++++++++++++++
 tb/tb_hilo_mul_unit.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/hilo_pkg.sv
// Shared definitions for the execute-stage HI/LO multiply unit: ALUCtl codes,
// FSM state encoding and small decode helpers.
package hilo_pkg;

  // ALUCtl operation codes handled (or explicitly ignored) by the HI/LO unit
  localparam logic [4:0] ALU_MULT  = 5'b00101;
  localparam logic [4:0] ALU_MULTU = 5'b01110;
  localparam logic [4:0] ALU_MADD  = 5'b01100;
  localparam logic [4:0] ALU_MSUB  = 5'b01101;
  localparam logic [4:0] ALU_MTHI  = 5'b10001;
  localparam logic [4:0] ALU_MTLO  = 5'b10011;
  localparam logic [4:0] ALU_MFHI  = 5'b10000;
  localparam logic [4:0] ALU_MFLO  = 5'b10010;
  // Three-operand mul writes the GPR file only; never touches HI/LO
  localparam logic [4:0] ALU_MUL   = 5'b11000;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StMul    = 2'd1,
    StCommit = 2'd2
  } state_e;

  // Multiply family: starts an iterative operation
  function automatic logic is_mul_op(input logic [4:0] code);
    return (code == ALU_MULT) || (code == ALU_MULTU) ||
           (code == ALU_MADD) || (code == ALU_MSUB);
  endfunction

  // Any op that reads or writes HI/LO and therefore must wait for a busy unit
  function automatic logic is_hilo_op(input logic [4:0] code);
    return is_mul_op(code) ||
           (code == ALU_MTHI) || (code == ALU_MTLO) ||
           (code == ALU_MFHI) || (code == ALU_MFLO);
  endfunction

endpackage

// File: rtl/mul_iter_core.sv
// Unsigned iterative shift-add multiplier. Loaded by start, advanced one
// iteration per cycle while step is high; done flags the final iteration.
module mul_iter_core
  import hilo_pkg::*;
#(
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned BITS_PER_CYCLE = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  step,
  input  logic [DATA_W-1:0]     mcand,
  input  logic [DATA_W-1:0]     mplier,
  output logic [2*DATA_W-1:0]   prod,
  output logic                  done
);

  localparam int unsigned Steps = DATA_W / BITS_PER_CYCLE;
  localparam int unsigned CntW  = $clog2(Steps + 1);

  logic [2*DATA_W-1:0] mcand_q, mcand_d;
  logic [2*DATA_W-1:0] prod_q, prod_d;
  logic [2*DATA_W-1:0] partial;
  logic [DATA_W-1:0]   mplier_q, mplier_d;
  logic [CntW-1:0]     count_q, count_d;

  // Next-state: load on start, otherwise retire BITS_PER_CYCLE multiplier bits per step
  always_comb begin
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    prod_d   = prod_q;
    count_d  = count_q;
    partial  = prod_q;
    for (int k = 0; k < int'(BITS_PER_CYCLE); k++) begin
      if (mplier_q[k]) begin
        partial = partial + (mcand_q << k);
      end
    end
    if (start) begin
      mcand_d  = {{DATA_W{1'b0}}, mcand};
      mplier_d = mplier;
      prod_d   = '0;
      count_d  = '0;
    end else if (step) begin
      prod_d   = partial;
      mcand_d  = mcand_q << BITS_PER_CYCLE;
      mplier_d = mplier_q >> BITS_PER_CYCLE;
      count_d  = count_q + 1'b1;
    end
  end

  // Datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      prod_q   <= '0;
      count_q  <= '0;
    end else begin
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      prod_q   <= prod_d;
      count_q  <= count_d;
    end
  end

  assign prod = prod_q;
  // High during the step whose edge retires the last multiplier bits
  assign done = step && (count_q == CntW'(Steps - 1));

endmodule

// File: rtl/hilo_mul_unit.sv
// Execute-stage HI/LO unit: multiply family on an iterative engine, HI/LO
// registers, mthi/mtlo/mfhi/mflo and the stall request to the hazard unit.
module hilo_mul_unit
  import hilo_pkg::*;
#(
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned BITS_PER_CYCLE = 1
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Enable,
  input  logic [4:0]        ALUCtl,
  input  logic              HiLoWrite,
  input  logic              Cancel,
  input  logic [DATA_W-1:0] A,
  input  logic [DATA_W-1:0] B,
  output logic [DATA_W-1:0] HiLoOut,
  output logic              Busy,
  output logic              Stall
);

  state_e              state_q, state_d;
  logic                sign_q, sign_d;
  logic [4:0]          op_q, op_d;
  logic [DATA_W-1:0]   hi_q, hi_d;
  logic [DATA_W-1:0]   lo_q, lo_d;

  logic                accept;
  logic                signed_op;
  logic [DATA_W-1:0]   a_mag, b_mag;
  logic                core_step, core_done;
  logic [2*DATA_W-1:0] core_prod;
  logic [2*DATA_W-1:0] prod_signed;
  logic [2*DATA_W-1:0] commit_val;
  logic                idle_write;

  assign accept     = (state_q == StIdle) && Enable && HiLoWrite && is_mul_op(ALUCtl) && !Cancel;
  assign idle_write = (state_q == StIdle) && Enable && HiLoWrite && !Cancel;
  assign signed_op  = (ALUCtl != ALU_MULTU);

  // Engine works on magnitudes; the sign is reapplied at commit
  assign a_mag = (signed_op && A[DATA_W-1]) ? -A : A;
  assign b_mag = (signed_op && B[DATA_W-1]) ? -B : B;

  assign core_step = (state_q == StMul) && !Cancel;

  mul_iter_core #(
    .DATA_W         (DATA_W),
    .BITS_PER_CYCLE (BITS_PER_CYCLE)
  ) u_core (
    .clk    (Clk),
    .rst    (Reset),
    .start  (accept),
    .step   (core_step),
    .mcand  (a_mag),
    .mplier (b_mag),
    .prod   (core_prod),
    .done   (core_done)
  );

  // Signed product and accumulate/subtract against current {HI,LO}, modulo 2^(2*DATA_W)
  always_comb begin
    prod_signed = sign_q ? (~core_prod + 1'b1) : core_prod;
    unique case (op_q)
      ALU_MADD: commit_val = {hi_q, lo_q} + prod_signed;
      ALU_MSUB: commit_val = {hi_q, lo_q} - prod_signed;
      default:  commit_val = prod_signed;
    endcase
  end

  // FSM next state: Cancel returns to idle from any busy state, beating commit
  always_comb begin
    state_d = state_q;
    sign_d  = sign_q;
    op_d    = op_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d = StMul;
          sign_d  = signed_op && (A[DATA_W-1] ^ B[DATA_W-1]);
          op_d    = ALUCtl;
        end
      end
      StMul: begin
        if (Cancel) begin
          state_d = StIdle;
        end else if (core_done) begin
          state_d = StCommit;
        end
      end
      StCommit: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // HI/LO next state: multiply commit or mthi/mtlo while idle
  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    if ((state_q == StCommit) && !Cancel) begin
      hi_d = commit_val[2*DATA_W-1:DATA_W];
      lo_d = commit_val[DATA_W-1:0];
    end else if (idle_write) begin
      if (ALUCtl == ALU_MTHI) hi_d = A;
      if (ALUCtl == ALU_MTLO) lo_d = A;
    end
  end

  // State and architectural registers; reset aborts any operation and clears HI/LO
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= StIdle;
      sign_q  <= 1'b0;
      op_q    <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      sign_q  <= sign_d;
      op_q    <= op_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  // Outputs: reads come straight from the registers, no bypass of a same-cycle write
  always_comb begin
    Busy  = (state_q != StIdle);
    Stall = Busy && Enable && is_hilo_op(ALUCtl);
    unique case (ALUCtl)
      ALU_MFHI: HiLoOut = hi_q;
      ALU_MFLO: HiLoOut = lo_q;
      default:  HiLoOut = '0;
    endcase
  end

endmodule

// File: tb/tb_hilo_mul_unit.sv
// Directed bench for hilo_mul_unit; reads go through a scoreboard fed by a
// reference model of HI/LO.
module tb_hilo_mul_unit;

  localparam logic [4:0] C_MULT  = 5'b00101;
  localparam logic [4:0] C_MULTU = 5'b01110;
  localparam logic [4:0] C_MADD  = 5'b01100;
  localparam logic [4:0] C_MSUB  = 5'b01101;
  localparam logic [4:0] C_MTHI  = 5'b10001;
  localparam logic [4:0] C_MTLO  = 5'b10011;
  localparam logic [4:0] C_MFHI  = 5'b10000;
  localparam logic [4:0] C_MFLO  = 5'b10010;
  localparam logic [4:0] C_MUL   = 5'b11000;
  localparam logic [4:0] C_ADD   = 5'b00010;

  logic        Clk = 1'b0;
  logic        Reset, Enable, HiLoWrite, Cancel;
  logic [4:0]  ALUCtl;
  logic [31:0] A, B, HiLoOut;
  logic        Busy, Stall;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] sb[$];
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  always #5 Clk = ~Clk;

  hilo_mul_unit #(
    .DATA_W         (32),
    .BITS_PER_CYCLE (1)
  ) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .Enable    (Enable),
    .ALUCtl    (ALUCtl),
    .HiLoWrite (HiLoWrite),
    .Cancel    (Cancel),
    .A         (A),
    .B         (B),
    .HiLoOut   (HiLoOut),
    .Busy      (Busy),
    .Stall     (Stall)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge Clk);
    #1;
  endtask

  task automatic drive(input logic en, input logic hw, input logic [4:0] code,
                       input logic [31:0] a, input logic [31:0] b);
    Enable    = en;
    HiLoWrite = hw;
    ALUCtl    = code;
    A         = a;
    B         = b;
  endtask

  task automatic bubble();
    drive(1'b0, 1'b0, 5'd0, 32'd0, 32'd0);
    Cancel = 1'b0;
  endtask

  // Reference: full-width product, then accumulate modulo 2^64
  task automatic model_apply(input logic [4:0] code, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    logic [63:0] acc;
    if (code == C_MULTU) p = {32'd0, a} * {32'd0, b};
    else p = 64'($signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b}));
    acc = {m_hi, m_lo};
    case (code)
      C_MADD:  acc = acc + p;
      C_MSUB:  acc = acc - p;
      default: acc = p;
    endcase
    m_hi = acc[63:32];
    m_lo = acc[31:0];
  endtask

  task automatic read_reg(input bit hi, input string tag);
    drive(1'b1, 1'b0, hi ? C_MFHI : C_MFLO, 32'd0, 32'd0);
    sb.push_back(hi ? m_hi : m_lo);
    @(negedge Clk);
    check(tag, HiLoOut, sb.pop_front());
    next_cycle();
    bubble();
  endtask

  // Issue a multiply, then hold an mflo in EX until the unit releases it
  task automatic run_mul(input logic [4:0] code, input logic [31:0] a, input logic [31:0] b,
                         input string tag, input bit probe_other);
    int stalls;
    int exp_stalls;
    drive(1'b1, 1'b1, code, a, b);
    model_apply(code, a, b);
    next_cycle();
    exp_stalls = 33;
    if (probe_other) begin
      drive(1'b1, 1'b0, C_ADD, 32'd1, 32'd2);
      @(negedge Clk);
      check({tag, "_other_nostall"}, {31'd0, Stall}, 32'd0);
      check({tag, "_other_busy"}, {31'd0, Busy}, 32'd1);
      next_cycle();
      exp_stalls = 32;
    end
    drive(1'b1, 1'b0, C_MFLO, 32'd0, 32'd0);
    sb.push_back(m_lo);
    stalls = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge Clk);
      if (!Stall) break;
      stalls++;
      next_cycle();
    end
    check({tag, "_stalls"}, 32'(stalls), 32'(exp_stalls));
    check({tag, "_busy_done"}, {31'd0, Busy}, 32'd0);
    check({tag, "_lo"}, HiLoOut, sb.pop_front());
    next_cycle();
    bubble();
    read_reg(1'b1, {tag, "_hi"});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    Reset = 1'b1;
    bubble();
    repeat (2) @(posedge Clk);
    #1;

    // Reset state
    drive(1'b1, 1'b0, C_MFHI, 32'd0, 32'd0);
    @(negedge Clk);
    check("reset_busy", {31'd0, Busy}, 32'd0);
    check("reset_stall", {31'd0, Stall}, 32'd0);
    check("reset_hi", HiLoOut, 32'd0);
    ALUCtl = C_MFLO;
    #1;
    check("reset_lo", HiLoOut, 32'd0);
    next_cycle();
    Reset = 1'b0;
    bubble();

    // Signed, unsigned and sign-cancelling products
    run_mul(C_MULT, 32'hFFFF_FFFD, 32'h0000_0005, "t1_mult", 1'b0);
    run_mul(C_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "t2_multu", 1'b1);
    run_mul(C_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "t2_mult", 1'b0);

    // mthi/mtlo then accumulate/subtract
    drive(1'b1, 1'b1, C_MTHI, 32'd0, 32'd0);
    @(negedge Clk);
    check("mthi_out_zero", HiLoOut, 32'd0);
    m_hi = 32'd0;
    next_cycle();
    drive(1'b1, 1'b1, C_MTLO, 32'h0000_000A, 32'd0);
    m_lo = 32'h0000_000A;
    next_cycle();
    bubble();
    read_reg(1'b0, "t3_mtlo");
    run_mul(C_MADD, 32'd4, 32'd5, "t3_madd", 1'b0);
    run_mul(C_MSUB, 32'd7, 32'd7, "t3_msub", 1'b0);

    // Three-operand mul with HiLoWrite set must not touch HI/LO
    drive(1'b1, 1'b1, C_MUL, 32'd123, 32'd456);
    next_cycle();
    bubble();
    check("mul_no_busy", {31'd0, Busy}, 32'd0);
    read_reg(1'b1, "mul_hi_kept");
    read_reg(1'b0, "mul_lo_kept");

    // Cancel ten cycles into MUL
    drive(1'b1, 1'b1, C_MULT, 32'd9, 32'd9);
    next_cycle();
    bubble();
    repeat (9) next_cycle();
    check("t5_busy_mid", {31'd0, Busy}, 32'd1);
    Cancel = 1'b1;
    next_cycle();
    Cancel = 1'b0;
    check("t5_cancel_idle", {31'd0, Busy}, 32'd0);
    read_reg(1'b1, "t5_cancel_hi");
    read_reg(1'b0, "t5_cancel_lo");

    // Cancel in COMMIT (accept edge + 32 edges)
    drive(1'b1, 1'b1, C_MULT, 32'd3, 32'd3);
    next_cycle();
    bubble();
    repeat (32) next_cycle();
    check("t5_busy_commit", {31'd0, Busy}, 32'd1);
    Cancel = 1'b1;
    next_cycle();
    Cancel = 1'b0;
    check("t5_commit_cancel_idle", {31'd0, Busy}, 32'd0);
    read_reg(1'b0, "t5_commit_lo");
    read_reg(1'b1, "t5_commit_hi");

    // Cancel in IDLE blocks mthi and accept
    drive(1'b1, 1'b1, C_MTHI, 32'hDEAD_BEEF, 32'd0);
    Cancel = 1'b1;
    next_cycle();
    drive(1'b1, 1'b1, C_MULT, 32'd2, 32'd2);
    next_cycle();
    bubble();
    check("cancel_idle_no_accept", {31'd0, Busy}, 32'd0);
    read_reg(1'b1, "cancel_idle_hi");

    // Asynchronous reset mid-MUL
    drive(1'b1, 1'b1, C_MULT, 32'd7, 32'd7);
    next_cycle();
    bubble();
    repeat (5) next_cycle();
    ALUCtl = C_MFHI;
    #2;
    Reset = 1'b1;
    #1;
    m_hi = 32'd0;
    m_lo = 32'd0;
    check("t6_reset_busy", {31'd0, Busy}, 32'd0);
    check("t6_reset_hi", HiLoOut, m_hi);
    ALUCtl = C_MFLO;
    #1;
    check("t6_reset_lo", HiLoOut, m_lo);
    next_cycle();
    Reset = 1'b0;
    bubble();
    run_mul(C_MULT, 32'd2, 32'd3, "t6_mult", 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
